cache_port_arbiter: RTL

//  Shares one blocking direct-mapped Cache between the instruction-fetch port (I, read-only) and the

---
 rtl/cache_arb_pkg.sv | 26 ++
 rtl/cache_rr_picker.sv | 23 ++
 rtl/cache_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache port arbiter: FSM states, port ids,
// arbitration modes and the latched cache request bundle.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } cache_req_t;

endpackage

// File: rtl/cache_rr_picker.sv
// Two-way request picker: fixed D-over-I priority or round-robin
// against the last served port. Purely combinational.
module cache_rr_picker
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  input  logic       mode,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      (req == 2'b11):
        grant = (!mode || last == PORT_I) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one blocking cache between the I and D ports.
// CACHE_ARB_STATS_EN adds saturating hit/miss/conflict counters.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req_valid,
  input  logic [31:0] d_addr,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        c_input_valid,
  output logic [31:0] c_addr,
  output logic        c_mem_read,
  output logic        c_mem_write,
  output logic [31:0] c_din,
  input  logic        c_is_ready,
  input  logic        c_output_valid,
  input  logic [31:0] c_dout
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] conflict_count
`endif
);

  arb_state_t state;
  port_id_t   last;
  port_id_t   gnt_port;
  cache_req_t cur;
  cache_req_t i_bundle;
  cache_req_t d_bundle;
  logic [1:0] req;
  logic [1:0] grant;
  logic       take;

  assign req  = {d_req_valid, i_req_valid};
  assign take = (state == ST_IDLE) && (|req) && c_is_ready;

  always_comb begin
    i_bundle.addr  = i_addr;
    i_bundle.rd    = 1'b1;
    i_bundle.wr    = 1'b0;
    i_bundle.wdata = 32'd0;
    d_bundle.addr  = d_addr;
    d_bundle.wdata = d_wdata;
    d_bundle.rd    = 1'b1;
    d_bundle.wr    = 1'b0;
    // neither flag reads; a set write flag always wins
    unique case ({d_mem_write, d_mem_read})
      2'b00, 2'b01: begin
        d_bundle.rd = 1'b1;
        d_bundle.wr = 1'b0;
      end
      2'b10, 2'b11: begin
        d_bundle.rd = 1'b0;
        d_bundle.wr = 1'b1;
      end
      default: begin
        d_bundle.rd = 1'b1;
        d_bundle.wr = 1'b0;
      end
    endcase
  end

  cache_rr_picker u_picker (
    .req   (req),
    .last  (last),
    .mode  (ARB_MODE != ARB_FIXED),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      last          <= PORT_I;
      gnt_port      <= PORT_I;
      cur           <= '0;
      c_input_valid <= 1'b0;
      i_rsp_valid   <= 1'b0;
      d_rsp_valid   <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
    end else begin
      c_input_valid <= 1'b0;
      i_rsp_valid   <= 1'b0;
      d_rsp_valid   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (take) begin
            state         <= ST_ISSUE;
            c_input_valid <= 1'b1;
            gnt_port      <= grant[1] ? PORT_D : PORT_I;
            cur           <= grant[1] ? d_bundle : i_bundle;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (c_output_valid) begin
            state <= ST_IDLE;
            last  <= gnt_port;
            if (gnt_port == PORT_D) begin
              d_rsp_valid <= 1'b1;
              d_rdata     <= c_dout;
            end else begin
              i_rsp_valid <= 1'b1;
              i_rdata     <= c_dout;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign c_addr      = cur.addr;
  assign c_mem_read  = cur.rd;
  assign c_mem_write = cur.wr;
  assign c_din       = cur.wdata;

`ifdef CACHE_ARB_STATS_EN
  logic first_wait;
  logic hit_ev;
  logic miss_ev;
  logic conf_ev;

  assign hit_ev  = (state == ST_WAIT) && first_wait && c_output_valid;
  assign miss_ev = (state == ST_WAIT) && first_wait && !c_output_valid;
  assign conf_ev = take && (req == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      first_wait     <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
      conflict_count <= '0;
    end else begin
      first_wait <= (state == ST_ISSUE);
      if (hit_ev && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (miss_ev && miss_count != '1)
        miss_count <= miss_count + 1'b1;
      if (conf_ev && conflict_count != '1)
        conflict_count <= conflict_count + 1'b1;
    end
  end
`endif

endmodule
